// File: rtl/demux_router.sv
`default_nettype none
// ============================================================================
// Module   : demux_router
// Brief    : 1-to-4 demux feeding four independent 2-entry FIFOs.
//            Optional per-channel pop counters under DEMUX_ROUTER_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module demux_router #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_sel,
    input  logic [DATA_W-1:0]     in_data,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [4*DATA_W-1:0]   out_data
`ifdef DEMUX_ROUTER_CNT_EN
    ,
    output logic [31:0]           cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_t;

    localparam logic [7:0] c_cnt_max = 8'hFF;

    logic [3:0] w_full;

    // Ready depends only on registered state and the selector, never on out_ready.
    assign in_ready = rst_n & ~w_full[in_sel];

    for (genvar k = 0; k < 4; k++) begin : g_ch
        fifo_state_t       r_state;
        fifo_state_t       w_state_nxt;
        logic [DATA_W-1:0] r_head;
        logic [DATA_W-1:0] r_tail;
        logic              w_push;
        logic              w_pop;

        assign w_push   = in_valid & in_ready & (in_sel == 2'(k));
        assign w_pop    = out_valid[k] & out_ready[k];
        assign w_full[k] = (r_state == ST_FULL);

        assign out_valid[k]                  = (r_state != ST_EMPTY);
        assign out_data[k*DATA_W +: DATA_W]  = r_head;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state <= ST_EMPTY;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) w_state_nxt = ST_ONE;
                end
                ST_ONE: begin
                    if (w_push && !w_pop)      w_state_nxt = ST_FULL;
                    else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
                end
                ST_FULL: begin
                    if (w_pop) w_state_nxt = ST_ONE;
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end

        // Head is the visible word; tail only holds the second entry when FULL.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_push) r_head <= in_data;
                    end
                    ST_ONE: begin
                        if (w_push && w_pop) r_head <= in_data;
                        else if (w_push)     r_tail <= in_data;
                    end
                    ST_FULL: begin
                        if (w_pop) r_head <= r_tail;
                    end
                    default: begin
                        r_head <= r_head;
                    end
                endcase
            end
        end

`ifdef DEMUX_ROUTER_CNT_EN
        logic [7:0] r_cnt;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt <= 8'd0;
            end else if (w_pop && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end

        assign cnt[8*k +: 8] = r_cnt;
`else
        logic w_unused_cnt;
        assign w_unused_cnt = ^c_cnt_max;
`endif
    end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_demux_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_router
// Brief    : Directed plus random stimulus against a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_router;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
`ifdef DEMUX_ROUTER_CNT_EN
    logic [31:0] cnt;
`endif

    demux_router #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX_ROUTER_CNT_EN
        ,
        .cnt       (cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] q [4][$];
    int         cnt_model [4];
    logic       model_on = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, compare against the model, advance the model.
    task automatic drive_cycle(input logic rst, input logic v, input logic [1:0] s,
                               input logic [7:0] d, input logic [3:0] r);
        logic [3:0] exp_ov;
        logic       push;
        @(negedge clk);
        rst_n = rst; in_valid = v; in_sel = s; in_data = d; out_ready = r;
        #1;
        if (model_on) begin
            check_eq("in_ready", {31'd0, in_ready}, {31'd0, rst && (q[s].size() < 2)});
            for (int k = 0; k < 4; k++) exp_ov[k] = (q[k].size() != 0);
            check_eq("out_valid", {28'd0, out_valid}, {28'd0, exp_ov});
            for (int k = 0; k < 4; k++)
                if (q[k].size() != 0)
                    check_eq($sformatf("out_data%0d", k), {24'd0, out_data[k*8 +: 8]}, {24'd0, q[k][0]});
`ifdef DEMUX_ROUTER_CNT_EN
            for (int k = 0; k < 4; k++)
                check_eq($sformatf("cnt%0d", k), {24'd0, cnt[8*k +: 8]}, cnt_model[k]);
`endif
        end
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                q[k].delete();
                cnt_model[k] = 0;
            end
        end else begin
            push = v && (q[s].size() < 2);
            for (int k = 0; k < 4; k++) begin
                if (r[k] && q[k].size() != 0) begin
                    void'(q[k].pop_front());
                    if (cnt_model[k] < 255) cnt_model[k]++;
                end
            end
            if (push) q[s].push_back(d);
        end
        @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'd0; out_ready = 4'd0;

        // Reset held two cycles with traffic offered
        drive_cycle(1'b0, 1'b1, 2'd0, 8'h33, 4'h0);
        model_on = 1'b1;
        drive_cycle(1'b0, 1'b1, 2'd0, 8'h33, 4'h0);
        #1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_out_valid", {28'd0, out_valid}, 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);

        // Basic routing, first edge after reset release
        drive_cycle(1'b1, 1'b1, 2'd2, 8'hA5, 4'h0);
        #1;
        check_eq("route_valid", {28'd0, out_valid}, 32'h4);
        check_eq("route_data", {24'd0, out_data[23:16]}, 32'hA5);
        drive_cycle(1'b1, 1'b0, 2'd0, 8'h00, 4'h4);

        // Fill channel 1 and stall
        drive_cycle(1'b1, 1'b1, 2'd1, 8'h11, 4'h0);
        drive_cycle(1'b1, 1'b1, 2'd1, 8'h22, 4'h0);
        #1;
        check_eq("full_rdy_sel1", {31'd0, in_ready}, 32'd0);
        in_sel = 2'd0;
        #1;
        check_eq("full_rdy_sel0", {31'd0, in_ready}, 32'd1);
        drive_cycle(1'b1, 1'b1, 2'd1, 8'h33, 4'h0);

        // FULL channel pops while a push to it is offered: push must be rejected
        drive_cycle(1'b1, 1'b1, 2'd1, 8'h44, 4'h2);
        #1;
        check_eq("fullpop_head", {24'd0, out_data[15:8]}, 32'h22);
        drive_cycle(1'b1, 1'b0, 2'd0, 8'h00, 4'h2);
        #1;
        check_eq("fullpop_empty", {31'd0, out_valid[1]}, 32'd0);

        // Reset mid-operation with channel 3 full
        drive_cycle(1'b1, 1'b1, 2'd3, 8'h5A, 4'h0);
        drive_cycle(1'b1, 1'b1, 2'd3, 8'h6B, 4'h0);
        drive_cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'h0);
        drive_cycle(1'b1, 1'b0, 2'd0, 8'h00, 4'h8);
        #1;
        check_eq("midrst_valid3", {31'd0, out_valid[3]}, 32'd0);
        check_eq("midrst_data3", {24'd0, out_data[31:24]}, 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive_cycle(($urandom_range(0, 59) != 0), 1'($urandom), 2'($urandom),
                        8'($urandom), 4'($urandom));
        end

`ifdef DEMUX_ROUTER_CNT_EN
        // Counter saturation: stream channel 0 with continuous pops
        drive_cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'h0);
        for (int i = 0; i < 302; i++) begin
            drive_cycle(1'b1, 1'b1, 2'd0, 8'(i), 4'h1);
        end
        drive_cycle(1'b1, 1'b0, 2'd0, 8'h00, 4'h1);
        #1;
        check_eq("cnt_sat", cnt, 32'h0000_00FF);
`endif

        drive_cycle(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
